// File: rtl/count_sequencer.sv
// count_sequencer: valid/ready-commanded up/hold/down sweep controller for the lab counter.
// Optional tick prescaler enabled by defining CNTSEQ_PRESCALE_EN (adds the pre_div port).
module count_sequencer #(
    parameter int WIDTH     = 8,
    parameter int PRE_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic [WIDTH-1:0] cmd_hold,
    input  logic             cmd_loop,
`ifdef CNTSEQ_PRESCALE_EN
    input  logic [PRE_WIDTH-1:0] pre_div,
`endif
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, UP, HOLD, DOWN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             loop_q, loop_d;
    logic             tick;

    if (PRE_WIDTH < 1) begin : g_pre_width_chk
        $error("count_sequencer: PRE_WIDTH must be at least 1");
    end

    assign cmd_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign dir       = state_q == UP || state_q == HOLD;
    assign done      = state_q == DONE;
    assign count     = count_q;

`ifdef CNTSEQ_PRESCALE_EN
    logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d, pre_div_q, pre_div_d;
    logic                 sweep;

    // Divider free-runs across UP/HOLD/DOWN so loop sweeps keep an even tick rate.
    assign sweep     = state_q == UP || state_q == HOLD || state_q == DOWN;
    assign tick      = sweep && pre_cnt_q == pre_div_q;
    assign pre_div_d = (cmd_valid && cmd_ready) ? pre_div : pre_div_q;
    assign pre_cnt_d = (!sweep || abort || tick) ? '0 : pre_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q <= '0;
            pre_div_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pre_div_q <= pre_div_d;
        end
    end
`else
    assign tick = busy;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        hold_cnt_d = hold_cnt_q;
        limit_d    = limit_q;
        hold_d     = hold_q;
        loop_d     = loop_q;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: if (cmd_valid) begin
                    limit_d = cmd_limit;
                    hold_d  = cmd_hold;
                    loop_d  = cmd_loop;
                    count_d = '0;
                    state_d = cmd_limit == '0 ? DONE : UP;
                end
                UP: if (tick) begin
                    count_d = count_q + 1'b1;
                    if (count_d == limit_q) begin
                        state_d    = HOLD;
                        hold_cnt_d = hold_q;
                    end
                end
                HOLD: if (tick) begin
                    state_d    = hold_cnt_q == '0 ? DOWN : HOLD;
                    hold_cnt_d = hold_cnt_q == '0 ? hold_cnt_q : hold_cnt_q - 1'b1;
                end
                DOWN: if (tick) begin
                    count_d = count_q - 1'b1;
                    if (count_q == WIDTH'(1)) state_d = loop_q ? UP : DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            hold_cnt_q <= '0;
            limit_q    <= '0;
            hold_q     <= '0;
            loop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            hold_cnt_q <= hold_cnt_d;
            limit_q    <= limit_d;
            hold_q     <= hold_d;
            loop_q     <= loop_d;
        end
    end
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: randomized bench checking count_sequencer against a closed-form sweep model.
module tb_count_sequencer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1, cmd_valid = 1'b0, cmd_loop = 1'b0, abort = 1'b0;
    logic [W-1:0] cmd_limit = '0, cmd_hold = '0;
    logic [3:0]   pre_div = '0;
    logic         cmd_ready, dir, busy, done;
    logic [W-1:0] count;

    int checks = 0, errors = 0;

    // Model: an accepted command plus the number of edges elapsed since its accept edge.
    bit m_act = 1'b0, m_loop = 1'b0;
    int m_c = 0, m_l = 0, m_h = 0, m_pd = 0;

    count_sequencer #(.WIDTH(W), .PRE_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_limit(cmd_limit), .cmd_hold(cmd_hold), .cmd_loop(cmd_loop),
`ifdef CNTSEQ_PRESCALE_EN
        .pre_div(pre_div),
`endif
        .abort(abort), .count(count), .dir(dir), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int e_cnt = 0, e_dir = 0, e_busy = 0, e_done = 0, p, pe;
        if (m_act) begin
            e_busy = 1;
            p = 2 * m_l + m_h + 1;
            if (m_l == 0 || (!m_loop && m_c == p * (m_pd + 1))) e_done = 1;
            else begin
                pe = m_c / (m_pd + 1);
                if (m_loop) pe = pe % p;
                e_cnt = pe <= m_l ? pe : (pe <= m_l + m_h + 1 ? m_l : p - pe);
                e_dir = int'(pe <= m_l + m_h);
            end
        end
        check("ready", int'(cmd_ready), int'(!m_act));
        check("count", int'(count), e_cnt);
        check("dir", int'(dir), e_dir);
        check("busy", int'(busy), e_busy);
        check("done", int'(done), e_done);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) m_act = 1'b0;
        else if (!m_act) begin
            if (cmd_valid) begin
                m_act  = 1'b1;
                m_c    = 0;
                m_l    = int'(cmd_limit);
                m_h    = int'(cmd_hold);
                m_loop = cmd_loop;
`ifdef CNTSEQ_PRESCALE_EN
                m_pd   = int'(pre_div);
`else
                m_pd   = 0;
`endif
            end
        end else if (abort) m_act = 1'b0;
        else begin
            m_c++;
            if (m_l == 0 || (!m_loop && m_c > (2 * m_l + m_h + 1) * (m_pd + 1))) m_act = 1'b0;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic issue(input int l, input int h, input bit lp, input int pd);
        cmd_valid = 1'b1;
        cmd_limit = W'(l);
        cmd_hold  = W'(h);
        cmd_loop  = lp;
        pre_div   = 4'(pd);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic run_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check(tag, int'(busy), 0);
    endtask

    initial begin
        int seq_a[8] = '{1, 2, 3, 3, 3, 2, 1, 0};
        int seq_b[9] = '{1, 2, 2, 1, 0, 1, 2, 2, 1};
        int n;
        step();
        step();
        rst = 1'b0;
        step();
        check("reset_ready", int'(cmd_ready), 1);

        // Reset in the middle of a sweep
        issue(5, 2, 1'b0, 0);
        n = 0;
        while (count != 3 && n < 20) begin
            step();
            n++;
        end
        check("mid_count3", int'(count), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_count", int'(count), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(cmd_ready), 1);

        // L=3 H=1 single sweep
        issue(3, 1, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("seq_a", int'(count), seq_a[i]);
        end
        check("seq_a_done", int'(done), 1);
        step();
        check("seq_a_ready", int'(cmd_ready), 1);
        check("seq_a_done_gone", int'(done), 0);

        // Zero limit goes straight to DONE
        issue(0, 4, 1'b0, 0);
        check("l0_done", int'(done), 1);
        check("l0_dir", int'(dir), 0);
        step();
        check("l0_ready", int'(cmd_ready), 1);

        // Looping sweep aborted in the second DOWN
        issue(2, 0, 1'b1, 0);
        for (int i = 0; i < 9; i++) begin
            step();
            check("seq_b", int'(count), seq_b[i]);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_count", int'(count), 0);
        check("abort_done", int'(done), 0);

        // Abort in IDLE does not block a same-cycle accept
        abort = 1'b1;
        issue(2, 1, 1'b0, 0);
        abort = 1'b0;
        check("idle_abort_busy", int'(busy), 1);

        // New commands offered while busy are ignored
        cmd_valid = 1'b1;
        n = 0;
        while (!done && n < 40) begin
            cmd_limit = W'($urandom_range(1, 200));
            cmd_hold  = W'($urandom_range(0, 200));
            cmd_loop  = 1'b1;
            step();
            n++;
        end
        cmd_valid = 1'b0;
        check("ignore_done_seen", int'(done), 1);
        step();

        // Full-scale limit with no wrap
        issue(255, 3, 1'b0, 0);
        run_idle(1000, "full_scale_idle");

`ifdef CNTSEQ_PRESCALE_EN
        issue(2, 0, 1'b0, 2);
        step(); step(); step();
        check("pre_cnt1", int'(count), 1);
        step(); step(); step();
        check("pre_cnt2", int'(count), 2);
        run_idle(40, "pre_idle");
`endif

        for (int i = 0; i < 6000; i++) begin
            rst       = ($urandom % 400) == 0;
            abort     = ($urandom % 50) == 0;
            cmd_valid = ($urandom % 3) == 0;
            cmd_limit = ($urandom % 20) == 0 ? W'($urandom) : W'($urandom % 8);
            cmd_hold  = W'($urandom % 4);
            cmd_loop  = ($urandom % 4) == 0;
            pre_div   = 4'($urandom % 4);
            step();
        end
        rst = 1'b0; abort = 1'b1; cmd_valid = 1'b0;
        step();
        check("final_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
